pingpong_weight_buffer: RTL
===========================

# pingpong_weight_buffer

Parametrised double-buffered (ping-pong) weight store feeding the systolic array's weight-load path. One bank fills from the host stream while the other drains toward the array. Bank swaps are automatic and handshake-safe: a swap happens only when a complete tile is loaded and the previous tile is fully consumed. Tiles are variable-length, framed by `in_last`, and a tile can optionally be replayed several times for weight reuse across activation tiles.

## Interface
- `DATA_W`, 8: weight word width.
- `DEPTH`, 16: entries per bank; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous clear, same effect as reset.
- `in_data`  in  DATA_W: weight word to store.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: write bank can accept a word.
- `in_last`  in  1: qualifies the accepted beat as the final word of the tile.
- `replay`  in  4: extra read passes per tile, sampled at swap; ignored unless `WBUF_REPLAY_EN`.
- `out_data`  out  DATA_W: registered weight word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts `out_data`.
- `out_last`  out  1: `out_data` is the final entry of the current pass.
- `wr_bank`  out  1: index of the bank currently being written.
- `rd_busy`  out  1: read bank holds an unreleased tile.
- `fill_level`  out  AW+1: words written into the current write bank.

## Operation
- Write side has two states, FILL and LOADED.
  - FILL: `in_ready`=1. An accepted beat (`in_valid && in_ready`) writes `mem[wr_bank][wr_ptr]` and increments `wr_ptr`.
  - The side moves to LOADED when `in_last` is accepted, or when the DEPTH-th word is accepted (implicit last).
  - Tile length is latched as `wr_ptr+1`, range 1..DEPTH, stored in AW+1 bits with no wrap.
  - LOADED: `in_ready`=0.
- Read side has two states, IDLE and READ.
- A swap occurs in any cycle where the write side is LOADED and the read side is IDLE. At the next edge:
  - `wr_bank` toggles.
  - The read side latches length and `replay`, and sets `rd_ptr`=0, `pass`=0, state READ.
  - The write side returns to FILL with `wr_ptr`=0.
- READ behaviour:
  - The output register loads `mem[rd_bank][rd_ptr]` when it is empty, or on an output handshake.
  - `out_last` is 1 when the held entry is `length-1`.
  - After the `out_last` handshake: if `pass < replay`, `pass` increments and `rd_ptr` returns to 0. Otherwise the read side goes to IDLE and the output register empties.
- `rd_busy` = (read state == READ) or `out_valid`.
- `out_valid` deasserted with `out_ready`=1 never advances any state. Stalls of any length hold `out_data`/`out_last` stable.

## Timing
- Reset/flush values:
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `wr_bank`=0, `rd_busy`=0, `fill_level`=0.
  - Both sides empty. Storage contents are don't-care.
- Write: `fill_level` updates one cycle after the handshake. `in_ready` falls in the cycle after the last beat is accepted.
- Swap at edge E: `in_ready`=1 and `out_valid`=1 (entry 0) are both visible after E.
- Read throughput is one word per cycle while `out_ready`=1, with no bubbles between passes.
- Release: the final handshake occurs at edge R. The read side is IDLE after R, so the earliest swap edge is R+1 and the next `out_valid` follows R+1. This gives exactly one empty output cycle when the next tile is already LOADED.
- Simultaneous `in_last` acceptance and final read handshake: the swap is evaluated in the following cycle.
- A write filling the bank in the same cycle a swap condition becomes true is impossible: the swap requires LOADED, which is registered.
- Reset asserted mid-tile discards both banks. `flush` has the same effect on the next edge and takes priority over all handshakes in that cycle.

## Configuration
- `WBUF_REPLAY_EN` defined:
  - `replay` is sampled at swap.
  - Each tile is emitted `replay+1` times (1..16 passes).
  - `out_last` pulses at the end of every pass.
- Not defined:
  - The pass counter logic is removed and `replay` is unused.
  - Each tile is emitted exactly once.

## Structure
- Package `wbuf_pkg`:
  - write-state enum {FILL, LOADED}.
  - read-state enum {IDLE, READ}.
  - replay counter width constant (4).
- Sub-module `wbuf_bank`:
  - Parameterised `DATA_W`×`DEPTH` array with synchronous write and synchronous read port.
  - Instantiated twice. Write/read enables are steered by `wr_bank`.

## Test plan
- Reset, then 16 beats 0x01..0x10 with no `in_last` → LOADED after beat 16, swap, output 0x01..0x10, `out_last` with 0x10, `rd_busy` falls.
- 5-beat tile (`in_last` on beat 5), `out_ready`=1 → 5 outputs, `out_last` on the 5th, `in_ready` high again the cycle after the swap.
- Back-to-back tiles A (4 words) and B (3 words), `out_ready`=1 → B is LOADED while A drains, exactly one `out_valid`=0 cycle between A's last word and B's first.
- Random `out_ready` stalls (~50%) → `out_data`/`out_last` stable while stalled, no word lost or duplicated.
- `WBUF_REPLAY_EN` with `replay`=2 on a 3-word tile 0xA0..0xA2 → nine outputs A0,A1,A2 ×3, `out_last` three times. Without the macro → three outputs.
- Assert `flush` while A drains and B fills → the next cycle shows `out_valid`=0, `in_ready`=1, `fill_level`=0, `wr_bank`=0. A new tile then streams correctly.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared types for the ping-pong weight buffer: write/read side state
// encodings and the replay counter width.
package wbuf_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    LOADED = 1'b1
  } wr_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  localparam int unsigned RPL_W = 4;

endpackage

// File: rtl/wbuf_bank.sv
// One DATA_W x DEPTH weight bank: synchronous write port and a registered
// synchronous read port. The read register doubles as the buffer's output
// register, so it has a reset/clear value while the array itself does not.
module wbuf_bank #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port with async reset and synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pingpong_weight_buffer.sv
// Double-buffered weight store. One bank fills from the host stream while the
// other drains toward the systolic array; banks swap when a full tile is
// loaded and the previous one is released.
// Optional feature: define WBUF_REPLAY_EN to emit each tile replay+1 times.
module pingpong_weight_buffer
  import wbuf_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [RPL_W-1:0]  replay,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              wr_bank,
  output logic              rd_busy,
  output logic [AW:0]       fill_level
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;

  logic              r_wr_bank;
  logic [AW:0]       r_wr_cnt;
  logic [AW:0]       r_wr_len;
  logic [AW:0]       r_rd_len;
  logic [AW:0]       r_rd_ptr;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_in_hs;
  logic              w_wr_done;
  logic              w_swap;
  logic              w_out_hs;
  logic              w_pass_end;
  logic              w_more_pass;
  logic              w_tile_end;
  logic              w_load;
  logic [AW:0]       w_fetch_idx;
  logic              w_rd_en;
  logic              w_rd_sel;
  logic [AW-1:0]     w_raddr;
  logic [1:0]        w_we;
  logic [1:0]        w_re;
  logic [DATA_W-1:0] w_rdata [2];

  assign w_in_hs     = in_valid && (r_wr_state == FILL);
  assign w_wr_done   = w_in_hs && (in_last || (r_wr_cnt == LAST_IDX));
  assign w_swap      = (r_wr_state == LOADED) && (r_rd_state == IDLE);
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_pass_end  = w_out_hs && r_out_last;
  assign w_tile_end  = w_pass_end && !w_more_pass;
  assign w_load      = (r_rd_state == READ) && (!r_out_valid || w_out_hs) && !w_tile_end;
  assign w_fetch_idx = w_pass_end ? '0 : r_rd_ptr;

`ifdef WBUF_REPLAY_EN
  logic [RPL_W-1:0] r_pass;
  logic [RPL_W-1:0] r_replay;

  assign w_more_pass = (r_pass != r_replay);

  // Pass counter: replay count is captured at swap, pass advances per out_last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass   <= '0;
      r_replay <= '0;
    end else if (flush) begin
      r_pass   <= '0;
      r_replay <= '0;
    end else if (w_swap) begin
      r_pass   <= '0;
      r_replay <= replay;
    end else if (w_pass_end && w_more_pass) begin
      r_pass   <= r_pass + 1'b1;
    end
  end
`else
  logic w_unused_replay;

  assign w_more_pass     = 1'b0;
  assign w_unused_replay = ^replay;
`endif

  // State registers for both sides; flush acts as a synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= FILL;
      r_rd_state <= IDLE;
    end else if (flush) begin
      r_wr_state <= FILL;
      r_rd_state <= IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Next-state logic for the write and read sides.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_rd_state_nxt = r_rd_state;
    case (r_wr_state)
      FILL:    if (w_wr_done) w_wr_state_nxt = LOADED;
      LOADED:  if (w_swap)    w_wr_state_nxt = FILL;
      default: w_wr_state_nxt = FILL;
    endcase
    case (r_rd_state)
      IDLE:    if (w_swap)     w_rd_state_nxt = READ;
      READ:    if (w_tile_end) w_rd_state_nxt = IDLE;
      default: w_rd_state_nxt = IDLE;
    endcase
  end

  // Write-side pointer, tile length capture and bank toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_len  <= '0;
    end else if (flush) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_len  <= '0;
    end else if (w_swap) begin
      r_wr_bank <= ~r_wr_bank;
      r_wr_cnt  <= '0;
    end else if (w_in_hs) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_done) r_wr_len <= r_wr_cnt + 1'b1;
    end
  end

  // Read-side pointer and output qualifiers. Entry 0 is fetched during the
  // swap cycle itself so it is visible right after the swap edge; rd_ptr
  // therefore always names the next entry to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_len    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (flush) begin
      r_rd_len    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_swap) begin
      r_rd_len    <= r_wr_len;
      r_rd_ptr    <= LEN_ONE;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_wr_len == LEN_ONE);
    end else if (w_load) begin
      r_rd_ptr    <= w_fetch_idx + 1'b1;
      r_out_valid <= 1'b1;
      r_out_last  <= (w_fetch_idx == (r_rd_len - 1'b1));
    end else if (w_tile_end) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Bank steering: writes go to wr_bank; reads come from the other bank,
  // except during a swap, when the just-loaded bank (still wr_bank) is read.
  assign w_rd_en  = !flush && (w_swap || w_load);
  assign w_rd_sel = w_swap ? r_wr_bank : ~r_wr_bank;
  assign w_raddr  = w_swap ? '0 : w_fetch_idx[AW-1:0];
  assign w_we     = {w_in_hs && !flush && r_wr_bank, w_in_hs && !flush && !r_wr_bank};
  assign w_re     = {w_rd_en && w_rd_sel, w_rd_en && !w_rd_sel};

  for (genvar g = 0; g < 2; g++) begin : g_bank
    wbuf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (flush),
      .i_we    (w_we[g]),
      .i_waddr (r_wr_cnt[AW-1:0]),
      .i_wdata (in_data),
      .i_re    (w_re[g]),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[g])
    );
  end

  assign in_ready   = (r_wr_state == FILL);
  assign out_data   = r_wr_bank ? w_rdata[0] : w_rdata[1];
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign wr_bank    = r_wr_bank;
  assign rd_busy    = (r_rd_state == READ) || r_out_valid;
  assign fill_level = r_wr_cnt;

endmodule
